// File: rtl/fp_operand_loader.sv
// Operand-entry stage for the 33-bit FP adder: debounces a push-button and
// assembles operands A then B byte by byte from an 8-bit switch bus.
module fp_operand_loader #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        load_btn,
    input  logic        clear,
    output logic [32:0] a,
    output logic [32:0] b,
    output logic        operands_valid,
    output logic        done_pulse,
    output logic [2:0]  byte_idx,
    output logic        loading_b
);

    localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        DONE
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    logic                   deb_lvl_q, deb_lvl_d;
    logic                   deb_prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   accept;

    state_e                 state_q, state_d;
    logic [2:0]             byte_idx_q, byte_idx_d;
    logic [32:0]            a_q, a_d;
    logic [32:0]            b_q, b_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   loading_b_q, loading_b_d;

    // Byte slots 0..3 fill the low 32 bits; slot 4 supplies only the sign bit.
    function automatic logic [32:0] load_byte(input logic [32:0] cur,
                                              input logic [2:0]  idx,
                                              input logic [7:0]  d);
        logic [32:0] r;
        r = cur;
        case (idx)
            3'd0:    r[7:0]   = d;
            3'd1:    r[15:8]  = d;
            3'd2:    r[23:16] = d;
            3'd3:    r[31:24] = d;
            3'd4:    r[32]    = d[0];
            default: r        = cur;
        endcase
        return r;
    endfunction

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // A press is the rising edge of the debounced level, so holding the
    // button produces a single accept and release produces none.
    assign accept = deb_lvl_q & ~deb_prev_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/case tree leaves it unassigned (which would infer a latch).
        deb_lvl_d = deb_lvl_q;
        cnt_d     = '0;
        if (sync_lvl != deb_lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_lvl_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        if (clear) begin
            state_d    = LOAD_A;
            byte_idx_d = 3'd0;
            a_d        = '0;
            b_d        = '0;
            valid_d    = 1'b0;
        end else if (accept) begin
            case (state_q)
                LOAD_A: begin
                    a_d = load_byte(a_q, byte_idx_q, data_in);
                    if (byte_idx_q == 3'd4) begin
                        byte_idx_d = 3'd0;
                        state_d    = LOAD_B;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
                LOAD_B: begin
                    b_d = load_byte(b_q, byte_idx_q, data_in);
                    if (byte_idx_q == 3'd4) begin
                        byte_idx_d = 3'd0;
                        state_d    = DONE;
                        done_d     = 1'b1;
                        valid_d    = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        loading_b_d = (state_d != LOAD_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            deb_lvl_q   <= 1'b0;
            deb_prev_q  <= 1'b0;
            cnt_q       <= '0;
            state_q     <= LOAD_A;
            byte_idx_q  <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            loading_b_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, making the shift chain and FSM order-independent.
            sync_q      <= {sync_q[SYNC_STAGES-2:0], load_btn};
            deb_lvl_q   <= deb_lvl_d;
            deb_prev_q  <= deb_lvl_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            loading_b_q <= loading_b_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign done_pulse     = done_q;
    assign byte_idx       = byte_idx_q;
    assign loading_b      = loading_b_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scoreboard bench for fp_operand_loader: stimulus pushes expected output
// snapshots, a negedge monitor pops one on every observed output change.
module tb_fp_operand_loader;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
        logic        valid;
        logic        done;
        logic [2:0]  idx;
        logic        lb;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        load_btn = 1'b0;
    logic        clear = 1'b0;
    logic [32:0] a, b;
    logic        operands_valid, done_pulse, loading_b;
    logic [2:0]  byte_idx;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    done_cycles = 0;
    snap_t exp_q[$];
    snap_t model = '0;
    snap_t prev  = '0;
    int    m_state = 0; // 0 = loading A, 1 = loading B, 2 = done

    fp_operand_loader #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_btn(load_btn),
        .clear(clear), .a(a), .b(b), .operands_valid(operands_valid),
        .done_pulse(done_pulse), .byte_idx(byte_idx), .loading_b(loading_b)
    );

    always #5 clk = ~clk;

    function automatic snap_t cur_snap();
        return {a, b, operands_valid, done_pulse, byte_idx, loading_b};
    endfunction

    always @(negedge clk) begin
        snap_t cur, e;
        cur = cur_snap();
        if (done_pulse === 1'b1) done_cycles++;
        if (cur !== prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got a=%h b=%h v=%b d=%b idx=%0d lb=%b, no change expected",
                         cur.a, cur.b, cur.valid, cur.done, cur.idx, cur.lb);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got a=%h b=%h v=%b d=%b idx=%0d lb=%b, want a=%h b=%h v=%b d=%b idx=%0d lb=%b",
                             cur.a, cur.b, cur.valid, cur.done, cur.idx, cur.lb,
                             e.a, e.b, e.valid, e.done, e.idx, e.lb);
                end
            end
            prev = cur;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_snap(input snap_t s);
        if (s !== model) exp_q.push_back(s);
        model = s;
    endtask

    task automatic model_accept(input logic [7:0] d);
        snap_t s;
        s = model;
        if (m_state == 2) return;
        if (s.idx < 3'd4) begin
            if (m_state == 0) s.a[8*s.idx +: 8] = d;
            else              s.b[8*s.idx +: 8] = d;
            s.idx = s.idx + 3'd1;
            expect_snap(s);
        end else if (m_state == 0) begin
            s.a[32] = d[0];
            s.idx   = 3'd0;
            s.lb    = 1'b1;
            m_state = 1;
            expect_snap(s);
        end else begin
            s.b[32] = d[0];
            s.idx   = 3'd0;
            s.valid = 1'b1;
            s.done  = 1'b1;
            m_state = 2;
            expect_snap(s);
            s.done  = 1'b0;
            expect_snap(s);
        end
    endtask

    task automatic press(input logic [7:0] d);
        @(negedge clk);
        data_in  = d;
        load_btn = 1'b1;
        model_accept(d);
        repeat (25) @(negedge clk);
        load_btn = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        expect_snap('0);
        m_state = 0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(cur_snap()), 64'(0));
        rst_n = 1'b1;

        // Partial load then asynchronous reset between clock edges
        press(8'h11);
        press(8'h22);
        press(8'h33);
        check("partial_a", 64'(a), 64'h33_2211);
        #2;
        rst_n = 1'b0;
        expect_snap('0);
        m_state = 0;
        #1;
        check("async_reset", 64'(cur_snap()), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 2.0 operands
        press(8'h00); press(8'h00); press(8'h80); press(8'h7F); press(8'h00);
        check("a_one", 64'(a), 64'h0_7F80_0000);
        check("lb_after_a", 64'(loading_b), 64'(1));
        press(8'h00); press(8'h00); press(8'h80); press(8'h80); press(8'h00);
        check("b_two", 64'(b), 64'h0_8080_0000);
        check("valid_done", 64'(operands_valid), 64'(1));
        check("done_width", 64'(done_cycles), 64'(1));

        // DONE ignores presses
        press(8'hAA); press(8'h55); press(8'hFF);
        check("done_hold_a", 64'(a), 64'h0_7F80_0000);
        check("done_hold_b", 64'(b), 64'h0_8080_0000);
        check("done_hold_v", 64'(operands_valid), 64'(1));
        check("done_no_pulse", 64'(done_cycles), 64'(1));

        // Sign byte with junk upper bits, then clear mid-B
        do_clear();
        press(8'h00); press(8'h00); press(8'h80); press(8'h7F); press(8'hFF);
        check("a_minus_one", 64'(a), 64'h1_7F80_0000);
        press(8'h12); press(8'h34);
        do_clear();
        @(negedge clk);
        check("clear_state", 64'(cur_snap()), 64'(0));

        // Bounce: two 15-cycle excursions must not register
        @(negedge clk);
        data_in = 8'hEE;
        load_btn = 1'b1; repeat (15) @(negedge clk);
        load_btn = 1'b0; repeat (5)  @(negedge clk);
        load_btn = 1'b1; repeat (15) @(negedge clk);
        load_btn = 1'b0; repeat (25) @(negedge clk);
        check("bounce_idx", 64'(byte_idx), 64'(0));

        // Stable 40-cycle press: one write at edge E+2+16
        @(negedge clk);
        data_in  = 8'h5A;
        load_btn = 1'b1;
        model_accept(8'h5A);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (first == 0 && byte_idx !== 3'd0) first = k;
        end
        @(negedge clk);
        load_btn = 1'b0;
        repeat (25) @(negedge clk);
        check("write_edge", 64'(first), 64'(19));
        check("single_write", 64'(a), 64'h5A);

        // Clear on the accept cycle: byte discarded
        @(negedge clk);
        data_in  = 8'hC3;
        load_btn = 1'b1;
        repeat (18) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        expect_snap('0);
        m_state = 0;
        @(negedge clk);
        clear = 1'b0;
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        repeat (25) @(negedge clk);
        check("clear_wins", 64'(cur_snap()), 64'(0));

        // Next press after debounced release lands in a[7:0]
        press(8'h3C);
        check("post_clear_a", 64'(a), 64'h3C);

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Upstream operand-entry stage for the 33-bit floating-point adder. It assembles operands A and B byte by byte from an 8-bit switch bus, driven by a bouncing push-button. It then presents both operands on stable registered outputs with a valid flag, so the combinational adder's sum can be displayed or captured. Operand format: bit 32 sign, bits 31:24 biased exponent (bias 127), bits 23:0 mantissa with explicit leading one.

## Interface
- SYNC_STAGES, 2: flip-flops in the load_btn synchronizer (≥2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a changed synchronized level must persist before it is accepted (≥1). The board build overrides this to about 1_000_000.
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  8  switch byte; sampled on the accepting edge.
- load_btn  in  1  raw push-button, asynchronous to clk, may bounce.
- clear  in  1  synchronous active-high restart; already synchronous to clk.
- a  out  33  operand A register.
- b  out  33  operand B register.
- operands_valid  out  1  high while both operands are complete.
- done_pulse  out  1  one-cycle strobe on completion of B.
- byte_idx  out  3  index (0..4) of the next byte to be written.
- loading_b  out  1  0 while loading A, 1 while loading B or done.

## Operation
- **Synchronizer:** load_btn passes through SYNC_STAGES flops to give sync_lvl.
- **Debouncer:** holds deb_lvl and a counter.
  - Counter clears when sync_lvl == deb_lvl.
  - Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES−1 and sync_lvl still differs, deb_lvl takes sync_lvl and the counter clears.
- **Accept:** a single-cycle pulse on a deb_lvl rising edge. Holding the button yields exactly one accept. Release generates nothing.
- **FSM states:** LOAD_A, LOAD_B, DONE.
  - LOAD_A, accept with byte_idx i<4: a[8i+7:8i] ← data_in, byte_idx++.
  - LOAD_A, accept with i=4: a[32] ← data_in[0], data_in[7:1] ignored, byte_idx ← 0, go to LOAD_B.
  - LOAD_B: same byte rules into b. On accept at i=4, go to DONE, assert done_pulse for that one cycle, set operands_valid.
  - DONE: accepts ignored; a, b, operands_valid hold until clear or reset.
- **clear, any state:** go to LOAD_A, byte_idx 0, a=b=0, operands_valid 0, done_pulse 0. Debouncer state is kept.
- **clear coincident with accept:** clear wins; the byte is discarded.
- Registers a and b are visible during partial load. Consumers must qualify them with operands_valid.

## Timing
- **Reset values:** a=0, b=0, operands_valid=0, done_pulse=0, byte_idx=0, loading_b=0, state LOAD_A, synchronizer flops 0, deb_lvl 0, counter 0.
- **Rise latency:** a load_btn rise held stable and first sampled at edge E:
  - deb_lvl rises at edge E+SYNC_STAGES+DEBOUNCE_CYCLES−1.
  - Byte written at the following edge.
- **Release latency:** the same SYNC_STAGES+DEBOUNCE_CYCLES−1 edges apply to deb_lvl falling. A new press is recognised only after a debounced release.
- **Short pulses:** any excursion of sync_lvl shorter than DEBOUNCE_CYCLES cycles produces no accept.
- **Completion:** operands_valid and done_pulse both rise on the edge that writes b[32]. done_pulse falls next edge.
- **Clock-domain note:** all outputs are registered; no combinational path from inputs to outputs.
- **Reset mid-operation:** reset at any time forces reset values immediately (asynchronous). Release is synchronous to the next clk edge.

## Test plan
- **Reset:** assert rst_n=0 mid-load (after 3 bytes) → all outputs return to reset values without a clock edge; next load writes a[7:0].
- **Positive operands:** load A bytes 00,00,80,7F,00 and B bytes 00,00,80,80,00 (DEBOUNCE_CYCLES=16) → a=0x0_7F800000 (1.0), b=0x0_80800000 (2.0), operands_valid=1, done_pulse high exactly one cycle, byte_idx sequence 0,1,2,3,4,0,…,4,0.
- **Sign byte:** load A with fifth byte 0xFF and bytes 00,00,80,7F → a=0x1_7F800000 (−1.0); bits 7:1 of the fifth byte ignored.
- **Bounce rejection:** load_btn high for 15 cycles, low, high for 15 cycles, low → no byte written, byte_idx stays 0. Hold high 40 cycles → exactly one write, at edge E+2+16.
- **Clear:** clear pulse after B byte 2 → state LOAD_A, a=b=0, byte_idx 0, loading_b=0. Clear on the same cycle as an accept → byte discarded.
- **DONE state:** in DONE, three further presses → a, b unchanged, done_pulse stays 0, operands_valid stays 1.
